// File: rtl/rat_table_pkg.sv
// -----------------------------------------------------------------------------
// rat_table_pkg
// Shared sizing and types for the register alias table.
//   RENAME_WIDTH : rename lanes, each with two read ports and one write port
//   COMMIT_WIDTH : commit lanes from the ROB, lane 0 oldest
//   NUM_AREGS    : architectural registers; areg 0 is hardwired to preg 0
//   NUM_PREGS    : physical registers; must exceed NUM_AREGS
// The reset mapping is the identity (areg a -> preg a). The free list therefore
// starts with pregs NUM_AREGS..NUM_PREGS-1.
// -----------------------------------------------------------------------------
package rat_table_pkg;

    localparam int RENAME_WIDTH = 2;
    localparam int COMMIT_WIDTH = 2;
    localparam int NUM_AREGS    = 32;
    localparam int NUM_PREGS    = 64;

    localparam int AREG_W   = $clog2(NUM_AREGS);
    localparam int PREG_W   = $clog2(NUM_PREGS);
    localparam int RD_PORTS = RENAME_WIDTH * 2;

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;

    // Whole alias map, indexed by areg.
    typedef preg_t [NUM_AREGS-1:0] map_t;

    // Reset image of both maps: every areg aliases the preg of the same index.
    function automatic map_t identity_map();
        map_t m;
        for (int a = 0; a < NUM_AREGS; a++) begin
            m[a] = preg_t'(a);
        end
        return m;
    endfunction

endpackage

// File: rtl/rat_map_bank.sv
// -----------------------------------------------------------------------------
// rat_map_bank
// One NUM_AREGS x preg_t alias map. It has NUM_WR lane-ordered write ports and
// a whole-map load port. The rat_table top uses two of these, one for the
// speculative map (SRAT) and one for the architectural map (ARAT).
//   clk, rst  : clock, asynchronous active-low reset to the identity map
//   wr_en     : per-lane write enable
//   wr_areg   : per-lane target areg; writes to areg 0 are ignored
//   wr_preg   : per-lane new alias
//   load_en   : replace the whole map with load_map; write ports are ignored
//   load_map  : full replacement image
//   map_q     : current map contents
// Lane priority: lanes are merged in ascending order. When two lanes target the
// same areg in one cycle, the higher (younger) lane's value is kept.
// -----------------------------------------------------------------------------
module rat_map_bank
    import rat_table_pkg::*;
#(
    parameter int NUM_WR = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WR-1:0] wr_en,
    input  areg_t [NUM_WR-1:0] wr_areg,
    input  preg_t [NUM_WR-1:0] wr_preg,
    input  logic              load_en,
    input  map_t              load_map,
    output map_t              map_q
);

    map_t map_d;

    always_comb begin
        map_d = map_q;
        if (load_en) begin
            map_d = load_map;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_areg[w] != '0)) begin
                    map_d[wr_areg[w]] = wr_preg[w];
                end
            end
        end
        // Entry 0 is pinned to preg 0. This holds even if a load image
        // carries something else there.
        map_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map_q <= identity_map();
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/rat_table.sv
// -----------------------------------------------------------------------------
// rat_table
// Register alias table. It answers the rename stage's read/write traffic and
// the ROB's commit traffic.
//   clk         : clock
//   rst         : asynchronous active-low reset; both maps return to identity
//   rd_areg     : src1/src2 areg per rename lane (port index = lane*2 + src)
//   rd_preg     : combinational alias for each read port; areg 0 -> preg 0
//   w_en        : rename write valid per lane
//   w_dst_areg  : rename destination areg per lane
//   w_new_alias : newly allocated preg per lane
//   cm_valid    : commit valid per lane, lane 0 oldest
//   cm_areg     : committed destination areg
//   cm_preg     : committed destination preg
//   flush       : restore the SRAT from the ARAT, with this cycle's commits
//                 applied; same-cycle rename writes are dropped
//   free_valid  : registered; a superseded preg is being returned on lane i
//   free_preg   : registered; the preg being returned on lane i
//   flush_done  : registered one-cycle pulse; the SRAT restore is complete
// Interface semantics: every request here is valid-only. The table accepts
// every write, commit and flush in the cycle it is presented, so there is no
// ready/backpressure. free_valid qualifies free_preg; the free list must
// accept a returned preg in the cycle free_valid is high.
// Optional build macro RAT_WR_BYPASS_EN: read ports forward this cycle's
// rename write aliases (youngest matching lane wins). The forward is
// suppressed while flush=1. Without the macro, reads see SRAT state only.
// -----------------------------------------------------------------------------
module rat_table
    import rat_table_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  areg_t [RD_PORTS-1:0]      rd_areg,
    output preg_t [RD_PORTS-1:0]      rd_preg,
    input  logic [RENAME_WIDTH-1:0]   w_en,
    input  areg_t [RENAME_WIDTH-1:0]  w_dst_areg,
    input  preg_t [RENAME_WIDTH-1:0]  w_new_alias,
    input  logic [COMMIT_WIDTH-1:0]   cm_valid,
    input  areg_t [COMMIT_WIDTH-1:0]  cm_areg,
    input  preg_t [COMMIT_WIDTH-1:0]  cm_preg,
    input  logic                      flush,
    output logic [COMMIT_WIDTH-1:0]   free_valid,
    output preg_t [COMMIT_WIDTH-1:0]  free_preg,
    output logic                      flush_done
);

    map_t                     srat_q;
    map_t                     arat_q;
    map_t                     arat_restore;
    logic [RENAME_WIDTH-1:0]  srat_wr_en;
    logic [COMMIT_WIDTH-1:0]  free_valid_d;
    preg_t [COMMIT_WIDTH-1:0] free_preg_d;

    // Rename writes that arrive together with a flush belong to the squashed
    // path, so they never reach the SRAT.
    assign srat_wr_en = flush ? '0 : w_en;

    // ARAT image after this cycle's commits. It is used as the SRAT restore
    // value, so a flush sees commits that retire in the same cycle.
    always_comb begin
        arat_restore = arat_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (cm_valid[i] && (cm_areg[i] != '0)) begin
                arat_restore[cm_areg[i]] = cm_preg[i];
            end
        end
    end

    rat_map_bank #(.NUM_WR(RENAME_WIDTH)) u_srat (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (srat_wr_en),
        .wr_areg  (w_dst_areg),
        .wr_preg  (w_new_alias),
        .load_en  (flush),
        .load_map (arat_restore),
        .map_q    (srat_q)
    );

    rat_map_bank #(.NUM_WR(COMMIT_WIDTH)) u_arat (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cm_valid),
        .wr_areg  (cm_areg),
        .wr_preg  (cm_preg),
        .load_en  (1'b0),
        .load_map ('0),
        .map_q    (arat_q)
    );

    // The superseded preg for commit lane i is its areg's architectural alias.
    // The exception is when an older lane in the same group committed the same
    // areg: then the older lane's preg is the one being displaced. Scanning
    // j upward leaves the nearest older lane in place.
    always_comb begin
        preg_t prior;
        prior        = '0;
        free_valid_d = '0;
        free_preg_d  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            prior = arat_q[cm_areg[i]];
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if ((j < i) && cm_valid[j] && (cm_areg[j] == cm_areg[i])) begin
                    prior = cm_preg[j];
                end
            end
            if (cm_valid[i] && (cm_areg[i] != '0)) begin
                free_valid_d[i] = 1'b1;
                free_preg_d[i]  = prior;
            end
        end
    end

    // Read ports.
    always_comb begin
        areg_t a;
        preg_t v;
        a       = '0;
        v       = '0;
        rd_preg = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            a = rd_areg[p];
            v = srat_q[a];
`ifdef RAT_WR_BYPASS_EN
            // Forward the alias rename is writing this cycle. This lets back-to-back
            // groups see their predecessor's destinations without a stall.
            if (!flush) begin
                for (int l = 0; l < RENAME_WIDTH; l++) begin
                    if (w_en[l] && (w_dst_areg[l] == a)) begin
                        v = w_new_alias[l];
                    end
                end
            end
`endif
            if (a == '0) begin
                v = '0;
            end
            rd_preg[p] = v;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_valid <= '0;
            free_preg  <= '0;
            flush_done <= 1'b0;
        end else begin
            free_valid <= free_valid_d;
            free_preg  <= free_preg_d;
            flush_done <= flush;
        end
    end

endmodule

// File: tb/tb_rat_table.sv
// -----------------------------------------------------------------------------
// tb_rat_table
// Directed bench for rat_table. A sequential model of the alias maps runs
// beside the DUT and is compared on every cycle. Literal expectations pin key
// scenarios. Honours RAT_WR_BYPASS_EN for the same-cycle read case.
// -----------------------------------------------------------------------------
module tb_rat_table;

    localparam int RW = 2;
    localparam int CW = 2;
    localparam int NA = 32;
    localparam int AW = 5;
    localparam int PW = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [RW*2*AW-1:0] rd_areg;
    logic [RW*2*PW-1:0] rd_preg;
    logic [RW-1:0]      w_en;
    logic [RW*AW-1:0]   w_dst_areg;
    logic [RW*PW-1:0]   w_new_alias;
    logic [CW-1:0]      cm_valid;
    logic [CW*AW-1:0]   cm_areg;
    logic [CW*PW-1:0]   cm_preg;
    logic               flush;
    logic [CW-1:0]      free_valid;
    logic [CW*PW-1:0]   free_preg;
    logic               flush_done;

    rat_table dut (
        .clk         (clk),
        .rst         (rst),
        .rd_areg     (rd_areg),
        .rd_preg     (rd_preg),
        .w_en        (w_en),
        .w_dst_areg  (w_dst_areg),
        .w_new_alias (w_new_alias),
        .cm_valid    (cm_valid),
        .cm_areg     (cm_areg),
        .cm_preg     (cm_preg),
        .flush       (flush),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .flush_done  (flush_done)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // ---------------- model state ----------------
    int srat_m[NA];
    int arat_m[NA];
    bit exp_fv[CW];
    int exp_fp[CW];
    bit exp_fd;

    function automatic int rd_a(int p);  return int'(rd_areg[p*AW +: AW]);     endfunction
    function automatic int rd_p(int p);  return int'(rd_preg[p*PW +: PW]);     endfunction
    function automatic int wd(int l);    return int'(w_dst_areg[l*AW +: AW]);  endfunction
    function automatic int wa(int l);    return int'(w_new_alias[l*PW +: PW]); endfunction
    function automatic int ca(int i);    return int'(cm_areg[i*AW +: AW]);     endfunction
    function automatic int cp(int i);    return int'(cm_preg[i*PW +: PW]);     endfunction
    function automatic int fp(int i);    return int'(free_preg[i*PW +: PW]);   endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rd_areg = '0; w_en = '0; w_dst_areg = '0; w_new_alias = '0;
        cm_valid = '0; cm_areg = '0; cm_preg = '0; flush = 1'b0;
    endtask

    task automatic set_rd(int p, int a);
        rd_areg[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_w(int l, int a, int pr);
        w_en[l] = 1'b1;
        w_dst_areg[l*AW +: AW] = AW'(a);
        w_new_alias[l*PW +: PW] = PW'(pr);
    endtask

    task automatic set_cm(int i, int a, int pr);
        cm_valid[i] = 1'b1;
        cm_areg[i*AW +: AW] = AW'(a);
        cm_preg[i*PW +: PW] = PW'(pr);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Commits are retired one at a time in lane order. Each commit hands back
    // whatever its areg mapped to just before it. Rename writes are applied the
    // same way. A flush instead copies the post-commit architectural map.
    always @(posedge clk or negedge rst) begin
        int tmp[NA];
        if (!rst) begin
            for (int a = 0; a < NA; a++) begin
                srat_m[a] = a;
                arat_m[a] = a;
            end
            for (int i = 0; i < CW; i++) begin
                exp_fv[i] = 1'b0;
                exp_fp[i] = 0;
            end
            exp_fd = 1'b0;
        end else begin
            tmp = arat_m;
            for (int i = 0; i < CW; i++) begin
                exp_fv[i] = 1'b0;
                if (cm_valid[i] && ca(i) != 0) begin
                    exp_fv[i] = 1'b1;
                    exp_fp[i] = tmp[ca(i)];
                    tmp[ca(i)] = cp(i);
                end
            end
            if (flush) begin
                srat_m = tmp;
            end else begin
                for (int l = 0; l < RW; l++) begin
                    if (w_en[l] && wd(l) != 0) srat_m[wd(l)] = wa(l);
                end
            end
            arat_m = tmp;
            exp_fd = flush;
        end
    end

    function automatic int exp_rd(int p);
        int a;
        int v;
        a = rd_a(p);
        v = (a == 0) ? 0 : srat_m[a];
`ifdef RAT_WR_BYPASS_EN
        if (!flush && a != 0) begin
            for (int l = 0; l < RW; l++) begin
                if (w_en[l] && wd(l) == a) v = wa(l);
            end
        end
`endif
        return v;
    endfunction

    // ---------------- scoreboard compare, mid-cycle ----------------
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            for (int p = 0; p < RW*2; p++) check("rd_preg", rd_p(p), exp_rd(p));
            for (int i = 0; i < CW; i++) begin
                check("free_valid", free_valid[i], exp_fv[i]);
                if (exp_fv[i]) check("free_preg", fp(i), exp_fp[i]);
            end
            check("flush_done", flush_done, exp_fd);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset image and areg 0
        @(negedge clk); idle();
        set_rd(0, 5); set_rd(1, 7); set_rd(2, 0); set_rd(3, 31);
        #4;
        check("rst_rd5", rd_p(0), 5);
        check("rst_rd7", rd_p(1), 7);
        check("rst_rd0", rd_p(2), 0);
        check("rst_fv", free_valid, 0);
        check("rst_fd", flush_done, 0);

        // Two lanes write areg 3; the younger lane wins
        @(negedge clk); idle();
        set_w(0, 3, 40); set_w(1, 3, 41); set_rd(0, 3);
        #4;
`ifdef RAT_WR_BYPASS_EN
        check("wr_same_cycle", rd_p(0), 41);
`else
        check("wr_same_cycle", rd_p(0), 3);
`endif
        @(negedge clk); idle(); set_rd(0, 3);
        #4 check("wr_conflict", rd_p(0), 41);

        // Two lanes commit areg 4
        @(negedge clk); idle();
        set_cm(0, 4, 40); set_cm(1, 4, 45);
        @(negedge clk); idle();
        #4;
        check("cm_fv", free_valid, 2'b11);
        check("cm_fp0", fp(0), 4);
        check("cm_fp1", fp(1), 40);

        // Speculative rename, then flush with a dropped write
        @(negedge clk); idle(); set_w(0, 6, 50);
        @(negedge clk); idle();
        flush = 1'b1; set_w(0, 7, 51); set_rd(0, 6); set_rd(1, 7);
        #4;
        check("pre_flush_rd6", rd_p(0), 50);
        check("flush_no_fwd", rd_p(1), 7);
        @(negedge clk); idle(); set_rd(0, 6); set_rd(1, 7); set_rd(2, 4);
        #4;
        check("flush_done", flush_done, 1);
        check("flush_rd6", rd_p(0), 6);
        check("flush_rd7", rd_p(1), 7);
        check("flush_rd4", rd_p(2), 45);
        @(negedge clk); idle();
        #4 check("flush_done_low", flush_done, 0);

        // Flush with a same-cycle commit, then a back-to-back flush
        @(negedge clk); idle(); flush = 1'b1; set_cm(0, 9, 52);
        @(negedge clk); idle(); flush = 1'b1; set_rd(0, 9);
        #4;
        check("ff_done1", flush_done, 1);
        check("ff_fv", free_valid, 2'b01);
        check("ff_fp0", fp(0), 9);
        check("ff_rd9", rd_p(0), 52);
        @(negedge clk); idle();
        #4 check("ff_done2", flush_done, 1);

        // Mixed traffic: overlapping writes, commits, occasional flush
        for (int k = 0; k < 24; k++) begin
            @(negedge clk); idle();
            if (k % 3 != 2) set_w(0, (k*7+1) % 32, 32 + (k % 32));
            if (k % 2 == 0) set_w(1, (k*3+2) % 32, 32 + ((k+11) % 32));
            if (k % 4 == 0) begin
                set_cm(0, (k*5) % 32, 33 + k);
                set_cm(1, (k*5) % 32, 40 + k);
            end else if (k % 4 == 1) begin
                set_cm(1, (k*5+3) % 32, 34 + k);
            end
            flush = (k % 9 == 8);
            set_rd(0, (k*7+1) % 32);
            set_rd(1, (k*3+2) % 32);
            set_rd(2, (k*11) % 32);
            set_rd(3, (k*5) % 32);
        end

        // Async reset in the middle of a cycle, while flush_done is due
        @(negedge clk); idle(); flush = 1'b1;
        @(negedge clk); idle();
        set_w(0, 8, 60); set_cm(0, 10, 61); set_rd(0, 3); set_rd(1, 4);
        #1 rst = 1'b0;
        #3;
        check("arst_rd3", rd_p(0), 3);
        check("arst_rd4", rd_p(1), 4);
        check("arst_fd", flush_done, 0);
        check("arst_fv", free_valid, 0);
        check("arst_fp", free_preg, 0);
        @(negedge clk); rst = 1'b1; idle();

        // Writes and commits to areg 0 are ignored
        @(negedge clk); idle();
        set_w(0, 0, 60); set_cm(0, 0, 61); set_rd(0, 0);
        @(negedge clk); idle(); set_rd(0, 0);
        #4;
        check("a0_rd", rd_p(0), 0);
        check("a0_fv", free_valid, 0);

        repeat (2) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
